// File: rtl/mmio_bulk_in_framer.sv
// Bulk-IN framer: gathers bytes from one of several AXI-S sources into a packet
// buffer, streams USB data packets (with ZDP/replay handling) and ends each command with an 8-byte status packet.
module mmio_bulk_in_framer #(
  parameter int          MAX_PACKET_LENGTH = 512,
  parameter int          CHANNELS          = 2,
  parameter int          TIMEOUT           = 256,
  parameter logic [31:0] MAGIC             = "TART",
  localparam int         CBITS             = $clog2(MAX_PACKET_LENGTH),
  localparam int         HBITS             = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  set_conf_i,
  input  logic                  clr_conf_i,
  input  logic [CBITS:0]        max_size_i,
  input  logic                  selected_i,
  input  logic                  ack_recv_i,
  input  logic                  timedout_i,
  output logic                  ep_ready_o,
  output logic                  stalled_o,
  output logic                  parity_o,
  input  logic                  cmd_vld_i,
  output logic                  cmd_ack_o,
  input  logic [HBITS-1:0]      cmd_chan_i,
  input  logic [3:0]            cmd_tag_i,
  input  logic [15:0]           cmd_len_i,
  output logic                  resp_done_o,
  input  logic [CHANNELS-1:0]   src_tvalid_i,
  input  logic [CHANNELS-1:0]   src_tlast_i,
  output logic [CHANNELS-1:0]   src_tready_o,
  input  logic [8*CHANNELS-1:0] src_tdata_i,
  output logic                  usb_tvalid_o,
  output logic                  usb_tlast_o,
  output logic                  usb_tkeep_o,
  input  logic                  usb_tready_i,
  output logic [7:0]            usb_tdata_o
);

  // state | meaning
  // IDLE  | waiting for a command (requires en_q)
  // FILL  | loading the packet buffer from the selected source
  // SEND  | streaming the buffered packet
  // WAIT  | awaiting host ACK/timeout for a data packet or ZDP
  // ZDP   | presenting the zero-length packet
  // STAT  | streaming the 8-byte status packet
  // SWAIT | awaiting host ACK/timeout for the status packet
  // HALT  | source stalled; left only by a configuration strobe
  typedef enum logic [2:0] {IDLE, FILL, SEND, WAIT, ZDP, STAT, SWAIT, HALT} state_t;

  localparam int               WBITS       = $clog2(TIMEOUT);
  localparam logic [WBITS-1:0] WDOG_RELOAD = WBITS'(TIMEOUT - 1);
  localparam logic [CBITS:0]   CNT_ONE     = (CBITS+1)'(1);

  state_t            state_q, state_d;
  logic              en_q, en_d;
  logic [HBITS-1:0]  chan_q, chan_d;
  logic [3:0]        tag_q, tag_d;
  logic [15:0]       resid_q, resid_d;
  logic [CBITS:0]    fcnt_q, fcnt_d;
  logic [CBITS:0]    plen_q, plen_d;
  logic [CBITS:0]    scnt_q, scnt_d;
  logic              done_q, done_d;
  logic              zdp_q, zdp_d;
  logic [1:0]        status_q, status_d;
  logic              parity_q, parity_d;
  logic              stalled_q, stalled_d;
  logic [WBITS-1:0]  wdog_q, wdog_d;

  logic [7:0]        buffer [MAX_PACKET_LENGTH];
  logic              beat_vld, beat_last;
  logic [7:0]        beat_data;
  logic              fill_beat, xfer_end, send_last, pkt_full;
  logic [CBITS:0]    fcnt_inc;
  logic [7:0]        stat_byte;

  always_comb begin
    beat_vld     = 1'b0;
    beat_last    = 1'b0;
    beat_data    = 8'h00;
    src_tready_o = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      if (chan_q == HBITS'(k)) begin
        beat_vld        = src_tvalid_i[k];
        beat_last       = src_tlast_i[k];
        beat_data       = src_tdata_i[8*k +: 8];
        src_tready_o[k] = (state_q == FILL);
      end
    end
  end

  assign fill_beat = (state_q == FILL) & beat_vld;
  assign fcnt_inc  = fcnt_q + CNT_ONE;
  assign pkt_full  = (fcnt_inc == max_size_i);
  assign xfer_end  = beat_last | (resid_q <= 16'd1);
  assign send_last = ((scnt_q + CNT_ONE) == plen_q);

  always_ff @(posedge clock) begin
    if (fill_beat) buffer[fcnt_q[CBITS-1:0]] <= beat_data;
  end

  always_comb begin
    case (scnt_q[2:0])
      3'd0:    stat_byte = MAGIC[7:0];
      3'd1:    stat_byte = MAGIC[15:8];
      3'd2:    stat_byte = MAGIC[23:16];
      3'd3:    stat_byte = MAGIC[31:24];
      3'd4:    stat_byte = {2'b00, status_q, tag_q};
      3'd5:    stat_byte = 8'h00;
      3'd6:    stat_byte = resid_q[7:0];
      default: stat_byte = resid_q[15:8];
    endcase
  end

  always_comb begin
    state_d      = state_q;
    en_d         = en_q;
    chan_d       = chan_q;
    tag_d        = tag_q;
    resid_d      = resid_q;
    fcnt_d       = fcnt_q;
    plen_d       = plen_q;
    scnt_d       = scnt_q;
    done_d       = done_q;
    zdp_d        = zdp_q;
    status_d     = status_q;
    parity_d     = parity_q;
    stalled_d    = stalled_q;
    wdog_d       = wdog_q;
    cmd_ack_o    = 1'b0;
    resp_done_o  = 1'b0;
    usb_tvalid_o = 1'b0;
    usb_tlast_o  = 1'b0;
    usb_tkeep_o  = 1'b0;
    usb_tdata_o  = 8'h00;
    case (state_q)
      IDLE: begin
        if (en_q && cmd_vld_i) begin
          cmd_ack_o = 1'b1;
          chan_d    = cmd_chan_i;
          tag_d     = cmd_tag_i;
          resid_d   = cmd_len_i;
          fcnt_d    = '0;
          scnt_d    = '0;
          done_d    = 1'b0;
          zdp_d     = 1'b0;
          status_d  = 2'd0;
          wdog_d    = WDOG_RELOAD;
          state_d   = (cmd_len_i != 16'd0) ? FILL : STAT;
        end
      end
      FILL: begin
        if (beat_vld) begin
          wdog_d  = WDOG_RELOAD;
          fcnt_d  = fcnt_inc;
          resid_d = (resid_q != 16'd0) ? resid_q - 16'd1 : 16'd0;
          if (pkt_full || xfer_end) begin
            plen_d  = fcnt_inc;
            scnt_d  = '0;
            done_d  = xfer_end;
            state_d = SEND;
            if (beat_last)
              status_d = (resid_q <= 16'd1) ? 2'd0 : 2'd1;
            else if (resid_q <= 16'd1)
              status_d = 2'd2;
          end
        end else if (wdog_q == '0) begin
          stalled_d = 1'b1;
          state_d   = HALT;
        end else begin
          wdog_d = wdog_q - 1'b1;
        end
      end
      SEND: begin
        usb_tvalid_o = 1'b1;
        usb_tkeep_o  = 1'b1;
        usb_tlast_o  = send_last;
        usb_tdata_o  = buffer[scnt_q[CBITS-1:0]];
        if (usb_tready_i) begin
          scnt_d = scnt_q + CNT_ONE;
          if (send_last) state_d = WAIT;
        end
      end
      WAIT: begin
        // ACK beats a simultaneous timeout.
        if (selected_i && ack_recv_i) begin
          parity_d = ~parity_q;
          scnt_d   = '0;
          if (zdp_q) begin
            state_d = STAT;
          end else if (!done_q) begin
            fcnt_d  = '0;
            wdog_d  = WDOG_RELOAD;
            state_d = FILL;
          end else if (plen_q == max_size_i) begin
            zdp_d   = 1'b1;
            state_d = ZDP;
          end else begin
            state_d = STAT;
          end
        end else if (selected_i && timedout_i) begin
          scnt_d  = '0;
          state_d = zdp_q ? ZDP : SEND;
        end
      end
      ZDP: begin
        usb_tvalid_o = 1'b1;
        usb_tlast_o  = 1'b1;
        if (usb_tready_i) state_d = WAIT;
      end
      STAT: begin
        usb_tvalid_o = 1'b1;
        usb_tkeep_o  = 1'b1;
        usb_tlast_o  = (scnt_q[2:0] == 3'd7);
        usb_tdata_o  = stat_byte;
        if (usb_tready_i) begin
          scnt_d = scnt_q + CNT_ONE;
          if (scnt_q[2:0] == 3'd7) state_d = SWAIT;
        end
      end
      SWAIT: begin
        if (selected_i && ack_recv_i) begin
          parity_d    = ~parity_q;
          resp_done_o = 1'b1;
          state_d     = IDLE;
        end else if (selected_i && timedout_i) begin
          scnt_d  = '0;
          state_d = STAT;
        end
      end
      default: ;
    endcase
    // Configuration strobes abort anything in flight, including HALT.
    if (set_conf_i || clr_conf_i) begin
      en_d        = set_conf_i & ~clr_conf_i;
      state_d     = IDLE;
      stalled_d   = 1'b0;
      parity_d    = 1'b0;
      cmd_ack_o   = 1'b0;
      resp_done_o = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      en_q      <= 1'b0;
      chan_q    <= '0;
      tag_q     <= '0;
      resid_q   <= '0;
      fcnt_q    <= '0;
      plen_q    <= '0;
      scnt_q    <= '0;
      done_q    <= 1'b0;
      zdp_q     <= 1'b0;
      status_q  <= '0;
      parity_q  <= 1'b0;
      stalled_q <= 1'b0;
      wdog_q    <= WDOG_RELOAD;
    end else begin
      state_q   <= state_d;
      en_q      <= en_d;
      chan_q    <= chan_d;
      tag_q     <= tag_d;
      resid_q   <= resid_d;
      fcnt_q    <= fcnt_d;
      plen_q    <= plen_d;
      scnt_q    <= scnt_d;
      done_q    <= done_d;
      zdp_q     <= zdp_d;
      status_q  <= status_d;
      parity_q  <= parity_d;
      stalled_q <= stalled_d;
      wdog_q    <= wdog_d;
    end
  end

  assign parity_o   = parity_q;
  assign stalled_o  = stalled_q;
  assign ep_ready_o = en_q & ~stalled_q &
                      ((state_q == SEND) | (state_q == ZDP) | (state_q == STAT));

endmodule

// File: tb/tb_mmio_bulk_in_framer.sv
// Directed bench for mmio_bulk_in_framer: a host/sink model records every USB packet
// and the results are compared with hand-derived packet lengths, bytes and status fields.
module tb_mmio_bulk_in_framer;

  localparam int TIMEOUT = 24;

  logic        clock, reset, set_conf, clr_conf;
  logic [9:0]  max_size;
  logic        selected, ack_recv, timedout;
  logic        ep_ready, stalled, parity;
  logic        cmd_vld, cmd_ack;
  logic [0:0]  cmd_chan;
  logic [3:0]  cmd_tag;
  logic [15:0] cmd_len;
  logic        resp_done;
  logic [1:0]  src_tvalid, src_tlast, src_tready;
  logic [15:0] src_tdata;
  logic        usb_tvalid, usb_tlast, usb_tkeep, usb_tready;
  logic [7:0]  usb_tdata;

  int total = 0;
  int bad   = 0;

  logic [7:0] rx_data [0:1023];
  logic       rx_keep [0:1023];
  int         pk_start [0:15];
  int         pk_len   [0:15];
  int         npkt, nrx, n_resp, n_tog, si_end;
  bit         fin, wrong_ready;

  mmio_bulk_in_framer #(
    .MAX_PACKET_LENGTH(512), .CHANNELS(2), .TIMEOUT(TIMEOUT), .MAGIC("TART")
  ) dut (
    .clock(clock), .reset(reset), .set_conf_i(set_conf), .clr_conf_i(clr_conf),
    .max_size_i(max_size), .selected_i(selected), .ack_recv_i(ack_recv),
    .timedout_i(timedout), .ep_ready_o(ep_ready), .stalled_o(stalled),
    .parity_o(parity), .cmd_vld_i(cmd_vld), .cmd_ack_o(cmd_ack),
    .cmd_chan_i(cmd_chan), .cmd_tag_i(cmd_tag), .cmd_len_i(cmd_len),
    .resp_done_o(resp_done), .src_tvalid_i(src_tvalid), .src_tlast_i(src_tlast),
    .src_tready_o(src_tready), .src_tdata_i(src_tdata), .usb_tvalid_o(usb_tvalid),
    .usb_tlast_o(usb_tlast), .usb_tkeep_o(usb_tkeep), .usb_tready_i(usb_tready),
    .usb_tdata_o(usb_tdata)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #1000000;
    $display("FAIL tb_watchdog: got no finish want finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] src_byte(input int i, input int ch);
    return 8'((i * 13 + ch * 5 + 1) & 255);
  endfunction

  // Issue one command, feed nsrc bytes on channel ch, act as host (ACK every
  // packet, except a single timeout on packet index to_pkt) until resp_done.
  task automatic run_xfer(input int ch, input int len, input logic [3:0] tg,
                          input int nsrc, input bit with_last, input int to_pkt);
    int si;
    bit pend, to_done;
    logic prev_par;
    si = 0; pend = 0; to_done = 0;
    npkt = 0; nrx = 0; pk_start[0] = 0; n_resp = 0; n_tog = 0; fin = 0; wrong_ready = 0;
    @(negedge clock);
    cmd_vld = 1'b1; cmd_chan = 1'(ch); cmd_tag = tg; cmd_len = 16'(len);
    #1 chk("cmd_ack", 32'(cmd_ack), 32'd1);
    prev_par = parity;
    @(negedge clock);
    cmd_vld = 1'b0;
    for (int cyc = 0; cyc < 4000 && !fin; cyc++) begin
      selected = 1'b0; ack_recv = 1'b0; timedout = 1'b0;
      src_tvalid = '0; src_tlast = '0; src_tdata = '0;
      if (si < nsrc) begin
        src_tvalid[ch]       = 1'b1;
        src_tlast[ch]        = with_last && (si == nsrc - 1);
        src_tdata[8*ch +: 8] = src_byte(si, ch);
      end
      if (pend) begin
        selected = 1'b1;
        pend     = 0;
        if (npkt - 1 == to_pkt && !to_done) begin
          timedout = 1'b1;
          to_done  = 1;
        end else begin
          ack_recv = 1'b1;
        end
      end
      #1;
      if (parity !== prev_par) n_tog++;
      prev_par = parity;
      if (src_tready[1-ch]) wrong_ready = 1;
      if (src_tvalid[ch] && src_tready[ch]) si++;
      if (usb_tvalid && nrx < 1024 && npkt < 15) begin
        rx_data[nrx] = usb_tdata;
        rx_keep[nrx] = usb_tkeep;
        nrx++;
        if (usb_tlast) begin
          pk_len[npkt] = nrx - pk_start[npkt];
          npkt++;
          pk_start[npkt] = nrx;
          pend = 1;
        end
      end
      if (resp_done) begin
        n_resp++;
        fin = 1;
      end
      @(negedge clock);
    end
    selected = 1'b0; ack_recv = 1'b0; timedout = 1'b0;
    src_tvalid = '0; src_tlast = '0;
    #1;
    if (parity !== prev_par) n_tog++;
    si_end = si;
    chk("xfer_done", 32'(fin), 32'd1);
    chk("ready_other_chan", 32'(wrong_ready), 32'd0);
    chk("resp_done_once", 32'(resp_done), 32'd0);
  endtask

  task automatic check_data(input int p, input int exp_len, input int first, input int ch);
    bit keep_ok;
    keep_ok = 1;
    chk("pkt_len", 32'(pk_len[p]), 32'(exp_len));
    for (int i = 0; i < exp_len; i++) begin
      chk("pkt_byte", 32'(rx_data[pk_start[p] + i]), 32'(src_byte(first + i, ch)));
      if (rx_keep[pk_start[p] + i] !== 1'b1) keep_ok = 0;
    end
    chk("pkt_keep", 32'(keep_ok), 32'd1);
  endtask

  task automatic check_stat(input int p, input logic [3:0] st, input logic [3:0] tg,
                            input logic [15:0] res);
    logic [7:0] exp [0:7];
    exp[0] = 8'h54; exp[1] = 8'h52; exp[2] = 8'h41; exp[3] = 8'h54;
    exp[4] = {st, tg}; exp[5] = 8'h00; exp[6] = res[7:0]; exp[7] = res[15:8];
    chk("stat_len", 32'(pk_len[p]), 32'd8);
    for (int i = 0; i < 8; i++)
      chk("stat_byte", 32'(rx_data[pk_start[p] + i]), 32'(exp[i]));
  endtask

  initial begin
    bit seen;
    reset = 1'b0; set_conf = 1'b0; clr_conf = 1'b0; max_size = 10'd64;
    selected = 1'b0; ack_recv = 1'b0; timedout = 1'b0;
    cmd_vld = 1'b0; cmd_chan = '0; cmd_tag = '0; cmd_len = '0;
    src_tvalid = '0; src_tlast = '0; src_tdata = '0; usb_tready = 1'b1;
    #2;
    chk("rst_usb_tvalid", 32'(usb_tvalid), 32'd0);
    chk("rst_ep_ready",   32'(ep_ready),   32'd0);
    chk("rst_stalled",    32'(stalled),    32'd0);
    chk("rst_parity",     32'(parity),     32'd0);
    chk("rst_src_tready", 32'(src_tready), 32'd0);
    @(negedge clock); @(negedge clock);
    reset = 1'b1;

    // commands are ignored until set_conf
    @(negedge clock);
    cmd_vld = 1'b1; cmd_len = 16'd5;
    #1 chk("ack_before_conf", 32'(cmd_ack), 32'd0);
    @(negedge clock);
    #1 chk("ack_before_conf2", 32'(cmd_ack), 32'd0);
    cmd_vld = 1'b0; set_conf = 1'b1;
    @(negedge clock);
    set_conf = 1'b0;

    // 5 bytes with tlast, len=5
    run_xfer(1, 5, 4'hA, 5, 1, -1);
    chk("t1_npkt", 32'(npkt), 32'd2);
    check_data(0, 5, 0, 1);
    check_stat(1, 4'h0, 4'hA, 16'd0);
    chk("t1_resp", 32'(n_resp), 32'd1);
    chk("t1_toggles", 32'(n_tog), 32'd2);

    // two full packets then a ZDP
    run_xfer(0, 128, 4'h3, 128, 1, -1);
    chk("t2_npkt", 32'(npkt), 32'd4);
    check_data(0, 64, 0, 0);
    check_data(1, 64, 64, 0);
    chk("t2_zdp_len", 32'(pk_len[2]), 32'd1);
    chk("t2_zdp_keep", 32'(rx_keep[pk_start[2]]), 32'd0);
    check_stat(3, 4'h0, 4'h3, 16'd0);
    chk("t2_toggles", 32'(n_tog), 32'd4);

    // timeout on first packet replays it, parity not toggled by the timeout
    max_size = 10'd8;
    run_xfer(1, 20, 4'h5, 20, 1, 0);
    chk("t3_npkt", 32'(npkt), 32'd5);
    check_data(0, 8, 0, 1);
    check_data(1, 8, 0, 1);
    check_data(2, 8, 8, 1);
    check_data(3, 4, 16, 1);
    check_stat(4, 4'h0, 4'h5, 16'd0);
    chk("t3_toggles", 32'(n_tog), 32'd4);

    // short transfer, then excess source without tlast
    max_size = 10'd64;
    run_xfer(0, 10, 4'h6, 4, 1, -1);
    chk("t4_npkt", 32'(npkt), 32'd2);
    check_data(0, 4, 0, 0);
    check_stat(1, 4'h1, 4'h6, 16'd6);
    run_xfer(1, 3, 4'h7, 6, 0, -1);
    chk("t5_npkt", 32'(npkt), 32'd2);
    check_data(0, 3, 0, 1);
    check_stat(1, 4'h2, 4'h7, 16'd0);
    chk("t5_consumed", 32'(si_end), 32'd3);

    // residual high byte
    run_xfer(0, 300, 4'h8, 2, 1, -1);
    check_data(0, 2, 0, 0);
    check_stat(1, 4'h1, 4'h8, 16'd298);

    // len=0: status only; leaves parity at 1
    run_xfer(1, 0, 4'h9, 0, 0, -1);
    chk("t7_npkt", 32'(npkt), 32'd1);
    check_stat(0, 4'h0, 4'h9, 16'd0);
    chk("t7_parity", 32'(parity), 32'd1);

    // watchdog: exactly TIMEOUT idle cycles in FILL
    @(negedge clock);
    cmd_vld = 1'b1; cmd_chan = 1'b0; cmd_len = 16'd8; cmd_tag = 4'h1;
    @(negedge clock);
    cmd_vld = 1'b0;
    repeat (TIMEOUT - 1) @(negedge clock);
    #1;
    chk("wd_not_yet", 32'(stalled), 32'd0);
    chk("wd_ready_before", 32'(src_tready), 32'd1);
    @(negedge clock);
    cmd_vld = 1'b1; cmd_len = 16'd0;
    #1;
    chk("wd_stalled", 32'(stalled), 32'd1);
    chk("wd_src_tready", 32'(src_tready), 32'd0);
    chk("wd_ep_ready", 32'(ep_ready), 32'd0);
    chk("wd_usb_tvalid", 32'(usb_tvalid), 32'd0);
    chk("wd_parity_kept", 32'(parity), 32'd1);
    chk("wd_no_cmd_in_halt", 32'(cmd_ack), 32'd0);
    cmd_vld = 1'b0;
    @(negedge clock);
    set_conf = 1'b1;
    @(negedge clock);
    set_conf = 1'b0;
    #1;
    chk("wd_cleared", 32'(stalled), 32'd0);
    chk("wd_parity_clr", 32'(parity), 32'd0);

    // asynchronous reset in the middle of SEND
    @(negedge clock);
    cmd_vld = 1'b1; cmd_chan = 1'b1; cmd_len = 16'd4; cmd_tag = 4'hB;
    @(negedge clock);
    cmd_vld = 1'b0;
    src_tvalid = 2'b10; src_tlast = 2'b10; src_tdata = 16'h5A00;
    seen = 0;
    for (int c = 0; c < 50 && !seen; c++) begin
      #1;
      if (usb_tvalid) seen = 1;
      else @(negedge clock);
    end
    chk("send_reached", 32'(seen), 32'd1);
    src_tvalid = '0; src_tlast = '0;
    #2 reset = 1'b0;
    #1;
    chk("arst_usb_tvalid", 32'(usb_tvalid), 32'd0);
    chk("arst_usb_tlast", 32'(usb_tlast), 32'd0);
    chk("arst_usb_tkeep", 32'(usb_tkeep), 32'd0);
    chk("arst_usb_tdata", 32'(usb_tdata), 32'd0);
    chk("arst_ep_ready", 32'(ep_ready), 32'd0);
    @(negedge clock); @(negedge clock);
    reset = 1'b1;
    cmd_vld = 1'b1; cmd_len = 16'd0;
    #1 chk("arst_cmd_ignored", 32'(cmd_ack), 32'd0);
    @(negedge clock);
    #1 chk("arst_cmd_ignored2", 32'(cmd_ack), 32'd0);
    cmd_vld = 1'b0; set_conf = 1'b1;
    @(negedge clock);
    set_conf = 1'b0;
    run_xfer(0, 0, 4'hC, 0, 0, -1);
    check_stat(0, 4'h0, 4'hC, 16'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
